// File: rtl/apb_reg_slave_pkg.sv
// Shared APB definitions: bus-state encoding and default widths.
package apb_pkg;

  localparam int APB_ADDR_W = 4;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB requester/completer signal bundle.
//
// Handshake: a transfer is offered by the requester with psel=1, penable=0
// (setup), then psel=1, penable=1 (access). The requester must hold the access
// phase until it sees pready=1; the transfer completes on the rising edge where
// psel & penable & pready are all 1. Read data on prdata is valid only in that
// completing cycle.
interface apb_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb_reg_slave_regfile.sv
// Register array: synchronous write, asynchronous read, synchronous clear.
module apb_regfile #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              pclk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear wins over write so a reset edge never commits a pending write.
  always_ff @(posedge pclk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/apb_reg_slave.sv
// APB completer in front of a 2**ADDR_W x DATA_W register file with a
// programmable number of wait states before pready.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int WAIT_STATES = 0
) (
  input  logic       pclk,
  input  logic       rst_n,      // active-high synchronous reset despite the name
  apb_if.slave       bus,
  output apb_state_t dbg_state
);
  localparam int              CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] WS_MAX = CNT_W'(WAIT_STATES);

  apb_state_t        state;
  apb_state_t        state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_nxt;
  logic              access_ph;
  logic              in_xfer;
  logic              ready;
  logic              we;
  logic [DATA_W-1:0] rd_word;

  assign access_ph = bus.psel & bus.penable;
  // SETUP counts as "in transfer" so the first access cycle can already complete.
  assign in_xfer   = (state == SETUP) || (state == ACCESS);
  assign ready     = ~rst_n & access_ph & in_xfer & (wait_cnt == WS_MAX);
  assign we        = ready & bus.pwrite;

  // Next bus state; an access phase seen from IDLE is demoted to SETUP.
  always_comb begin
    state_nxt = state;
    if (!bus.psel)          state_nxt = IDLE;
    else if (!bus.penable)  state_nxt = SETUP;
    else if (ready)         state_nxt = IDLE;
    else if (state == IDLE) state_nxt = SETUP;
    else                    state_nxt = ACCESS;
  end

  // Wait counter advances only on non-completing access cycles of a real transfer.
  always_comb begin
    wait_cnt_nxt = '0;
    if (access_ph && in_xfer && !ready && (wait_cnt < WS_MAX))
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
  end

  // State and counter registers.
  always_ff @(posedge pclk) begin
    if (rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  apb_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regfile (
    .pclk  (pclk),
    .clr   (rst_n),
    .we    (we),
    .waddr (bus.paddr),
    .wdata (bus.pwdata),
    .raddr (bus.paddr),
    .rdata (rd_word)
  );

  assign bus.pready = ready;
  assign bus.prdata = (~rst_n & access_ph & ~bus.pwrite) ? rd_word : '0;
  assign dbg_state  = state;
endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: one zero-wait and one two-wait instance, directed
// scenarios followed by random traffic, checked every cycle against a
// transfer-level model of the bus and register contents.
module tb_apb_reg_slave;
  import apb_pkg::*;

  // ---------------- clock / reset ----------------
  logic pclk;
  logic rst_n;
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- per-instance bus drive ----------------
  logic       psel_a    [2];
  logic       penable_a [2];
  logic       pwrite_a  [2];
  logic [3:0] paddr_a   [2];
  logic [7:0] pwdata_a  [2];
  apb_state_t dbg0, dbg1;

  apb_if #(.ADDR_W(4), .DATA_W(8)) bus0 ();
  apb_if #(.ADDR_W(4), .DATA_W(8)) bus1 ();

  assign bus0.psel    = psel_a[0];
  assign bus0.penable = penable_a[0];
  assign bus0.pwrite  = pwrite_a[0];
  assign bus0.paddr   = paddr_a[0];
  assign bus0.pwdata  = pwdata_a[0];
  assign bus1.psel    = psel_a[1];
  assign bus1.penable = penable_a[1];
  assign bus1.pwrite  = pwrite_a[1];
  assign bus1.paddr   = paddr_a[1];
  assign bus1.pwdata  = pwdata_a[1];

  apb_reg_slave #(.ADDR_W(4), .DATA_W(8), .WAIT_STATES(0)) dut0 (
    .pclk (pclk), .rst_n (rst_n), .bus (bus0), .dbg_state (dbg0)
  );
  apb_reg_slave #(.ADDR_W(4), .DATA_W(8), .WAIT_STATES(2)) dut1 (
    .pclk (pclk), .rst_n (rst_n), .bus (bus1), .dbg_state (dbg1)
  );

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 2;
  endfunction
  function automatic logic rdy(input int d);
    return (d == 0) ? bus0.pready : bus1.pready;
  endfunction
  function automatic logic [7:0] rdat(input int d);
    return (d == 0) ? bus0.prdata : bus1.prdata;
  endfunction

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transfer is "open" once a setup (or a stray access from idle) has been seen;
  // it completes after exactly ws(d) non-ready access cycles.
  logic [7:0] mem_m   [2][16];
  bit         started [2];
  int         n_acc   [2];

  function automatic bit exp_rdy(input int d);
    return !rst_n && psel_a[d] && penable_a[d] && started[d] && (n_acc[d] == ws(d));
  endfunction

  always @(posedge pclk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n) begin
        started[d] <= 1'b0;
        n_acc[d]   <= 0;
        for (int a = 0; a < 16; a++) mem_m[d][a] <= 8'h00;
      end else if (!psel_a[d]) begin
        started[d] <= 1'b0;
      end else if (!penable_a[d] || !started[d]) begin
        started[d] <= 1'b1;
        n_acc[d]   <= 0;
      end else if (exp_rdy(d)) begin
        started[d] <= 1'b0;
        if (pwrite_a[d]) mem_m[d][paddr_a[d]] <= pwdata_a[d];
      end else begin
        n_acc[d] <= n_acc[d] + 1;
      end
    end
  end

  // Compare process: pready and prdata are defined on every cycle.
  always @(negedge pclk) begin
    for (int d = 0; d < 2; d++) begin
      logic [7:0] exp_d;
      exp_d = (!rst_n && psel_a[d] && penable_a[d] && !pwrite_a[d]) ? mem_m[d][paddr_a[d]] : 8'h00;
      chk($sformatf("pready[%0d]", d), 32'(rdy(d)), 32'(exp_rdy(d)));
      chk($sformatf("prdata[%0d]", d), 32'(rdat(d)), 32'(exp_d));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int d, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge pclk); #1;
      psel_a[d]    = 1'b0;
      penable_a[d] = 1'b0;
    end
  endtask

  // One transfer; skip_setup starts directly in the access phase.
  task automatic xfer(input int d, input bit wr, input logic [3:0] a, input logic [7:0] wd,
                      input bit skip_setup, output logic [7:0] rd, output int cyc, output int low);
    bit done;
    done = 1'b0;
    rd   = 8'h00;
    @(posedge pclk); #1;
    psel_a[d]    = 1'b1;
    penable_a[d] = skip_setup;
    pwrite_a[d]  = wr;
    paddr_a[d]   = a;
    pwdata_a[d]  = wd;
    cyc = 1;
    low = 0;
    if (!skip_setup) begin
      @(posedge pclk); #1;
      penable_a[d] = 1'b1;
      cyc++;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge pclk);
      if (rdy(d)) begin
        rd   = rdat(d);
        done = 1'b1;
        break;
      end
      low++;
      @(posedge pclk); #1;
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout[%0d]: pready never rose, got 0 expected 1", d);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] rd;
  int         cyc, low;
  logic [3:0] wa [4] = '{4'd2, 4'd3, 4'd4, 4'd5};
  logic [7:0] wv [4] = '{8'd5, 8'd10, 8'd5, 8'd10};

  initial begin
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      psel_a[d] = 1'b0; penable_a[d] = 1'b0; pwrite_a[d] = 1'b0;
      paddr_a[d] = '0;  pwdata_a[d] = '0;
    end
    repeat (4) @(posedge pclk);
    @(negedge pclk);
    chk("reset_state0", 32'(dbg0), 32'(IDLE));
    chk("reset_state1", 32'(dbg1), 32'(IDLE));
    @(posedge pclk); #1;
    rst_n = 1'b0;

    // Read after reset, zero wait.
    xfer(0, 1'b0, 4'd7, 8'h00, 1'b0, rd, cyc, low);
    chk("rst_read_data", 32'(rd), 32'h00);
    chk("rst_read_cycles", 32'(cyc), 32'd2);
    idle(0, 1);

    // Back-to-back writes then reads.
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, wa[i], wv[i], 1'b0, rd, cyc, low);
      chk("b2b_wr_cycles", 32'(cyc), 32'd2);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b0, wa[i], 8'h00, 1'b0, rd, cyc, low);
      chk("b2b_rd_data", 32'(rd), 32'(wv[i]));
      chk("b2b_rd_cycles", 32'(cyc), 32'd2);
    end

    // Same sequence with an idle cycle between transfers.
    for (int i = 0; i < 8; i++) begin
      xfer(0, (i < 4), wa[i % 4], wv[i % 4], 1'b0, rd, cyc, low);
      if (i >= 4) chk("gap_rd_data", 32'(rd), 32'(wv[i % 4]));
      idle(0, 1);
      @(negedge pclk);
      chk("gap_state_idle", 32'(dbg0), 32'(IDLE));
    end

    // Two wait states.
    xfer(1, 1'b1, 4'd9, 8'hA5, 1'b0, rd, cyc, low);
    chk("ws_low_cycles", 32'(low), 32'd2);
    chk("ws_total_cycles", 32'(cyc), 32'd4);
    idle(1, 1);
    xfer(1, 1'b0, 4'd9, 8'h00, 1'b0, rd, cyc, low);
    chk("ws_read_data", 32'(rd), 32'hA5);
    idle(1, 1);

    // Abort by dropping psel in a wait state.
    @(posedge pclk); #1;
    psel_a[1] = 1'b1; penable_a[1] = 1'b0; pwrite_a[1] = 1'b1;
    paddr_a[1] = 4'd6; pwdata_a[1] = 8'h3C;
    @(posedge pclk); #1;
    penable_a[1] = 1'b1;
    @(negedge pclk);
    chk("abort_wait_low", 32'(rdy(1)), 32'd0);
    idle(1, 2);
    xfer(1, 1'b0, 4'd6, 8'h00, 1'b0, rd, cyc, low);
    chk("abort_psel_read", 32'(rd), 32'h00);
    idle(1, 1);

    // Abort by reset in the access phase.
    @(posedge pclk); #1;
    psel_a[1] = 1'b1; penable_a[1] = 1'b0; pwrite_a[1] = 1'b1;
    paddr_a[1] = 4'd6; pwdata_a[1] = 8'h3C;
    @(posedge pclk); #1;
    penable_a[1] = 1'b1;
    @(posedge pclk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      chk("abort_rst_pready", 32'(rdy(1)), 32'd0);
    end
    @(posedge pclk); #1;
    rst_n = 1'b0;
    psel_a[1] = 1'b0; penable_a[1] = 1'b0;
    @(negedge pclk);
    chk("abort_rst_state", 32'(dbg1), 32'(IDLE));
    xfer(1, 1'b0, 4'd6, 8'h00, 1'b0, rd, cyc, low);
    chk("abort_rst_read", 32'(rd), 32'h00);
    idle(1, 1);

    // Address extremes and an access with no setup.
    xfer(0, 1'b1, 4'd15, 8'hFF, 1'b0, rd, cyc, low);
    xfer(0, 1'b1, 4'd0, 8'h01, 1'b0, rd, cyc, low);
    xfer(0, 1'b0, 4'd15, 8'h00, 1'b0, rd, cyc, low);
    chk("edge_rd_15", 32'(rd), 32'hFF);
    xfer(0, 1'b0, 4'd0, 8'h00, 1'b0, rd, cyc, low);
    chk("edge_rd_0", 32'(rd), 32'h01);
    idle(0, 1);
    xfer(0, 1'b0, 4'd15, 8'h00, 1'b1, rd, cyc, low);
    chk("nosetup_low", 32'(low), 32'd1);
    chk("nosetup_data", 32'(rd), 32'hFF);
    idle(0, 1);
    xfer(1, 1'b1, 4'd3, 8'h77, 1'b1, rd, cyc, low);
    chk("nosetup_ws_low", 32'(low), 32'd3);
    idle(1, 1);

    // Random traffic on both instances.
    for (int i = 0; i < 200; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
      xfer(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 7) == 0), rd, cyc, low);
      idle(d, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) idle(d, 1);
    end
    idle(0, 1);
    idle(1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
